fp_add_arbiter: RTL and testbench
=================================

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one Adder.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles to wait for Adder completion.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 req  input  N_REQ  per-requester level request; operands stable while high.
REQ-006 op_a  input  32*N_REQ  packed IEEE-754 operand A; slice i belongs to requester i.
REQ-007 op_b  input  32*N_REQ  packed IEEE-754 operand B; slice i belongs to requester i.
REQ-008 done  output  N_REQ  one-cycle completion pulse to the served requester.
REQ-009 result  output  32  sum for the requester pulsed on done; valid only during that pulse.
REQ-010 err  output  1  qualifies done: 1 = timeout, result forced 0.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 add_en  output  1  Adder En; one-cycle start pulse.
REQ-013 add_a, add_b  output  32 each  Adder operands, registered, held from ISSUE until next ISSUE.
REQ-014 add_sum  input  32  Adder Sum.
REQ-015 add_ready  input  1  Adder Ready.

Function
REQ-016 FSM states, 1-hot or encoded: IDLE, ISSUE, WAIT, RESP.
- IDLE->ISSUE: any req bit high.
- ISSUE->WAIT: unconditional.
- WAIT->RESP: add_ready rising edge, or timeout.
- RESP->IDLE: unconditional.
REQ-017 Arbitration in IDLE: round-robin starting at pointer ptr. Grant = first req bit at or after ptr, wrapping modulo N_REQ.
REQ-018 On grant, latch the grant index and that requester's op_a/op_b slices into add_a/add_b. Set ptr = grant index + 1 mod N_REQ.
REQ-019 add_en is 1 for exactly the ISSUE cycle and 0 otherwise.
REQ-020 Completion is a rising edge of add_ready, detected against a registered copy. If add_ready is high in the ISSUE cycle, that value is not a completion; a fresh low-to-high transition is required.
REQ-021 Cycle counter:
- cleared in ISSUE;
- increments each WAIT cycle;
- on reaching TIMEOUT-1 without completion, exits to RESP with err=1.
REQ-022 Completion in WAIT: capture add_sum into the result register, err=0.
REQ-023 RESP cycle:
- done[grant]=1, all other done bits 0;
- result and err driven from registers;
- outside RESP, done=0, result=0, err=0.
REQ-024 Minimum turnaround from req seen in IDLE to done pulse is 4 cycles when the Adder completes 1 cycle after add_en.
REQ-025 req dropping mid-operation is ignored; the operation completes and done still pulses.
REQ-026 Requests arriving outside IDLE wait; they are never lost while held.
REQ-027 Completion and timeout in the same cycle: completion wins, err=0.
REQ-028 No operand inspection. NaN, Inf and zero pass through unchanged; rounding and overflow are owned by the Adder.

Reset
REQ-029 Reset is asynchronous, and while active-low reset is asserted: state=IDLE, ptr=0, counter=0, done=0, result=0, err=0, busy=0, add_en=0, add_a=0, add_b=0.
REQ-030 Reset asserted mid-operation aborts the transaction with no done pulse. After deassertion the first grant starts from ptr=0.

Structure
REQ-031 Shared package fp_arb_pkg holds:
- the FSM state enum type;
- default N_REQ and TIMEOUT constants;
- the IEEE-754 width constant 32.
REQ-032 One sub-module, rr_pick: combinational round-robin selector (inputs req, ptr; outputs grant index and any-valid).
REQ-033 The Adder is not instantiated inside; it is connected at the parent level.

Verification
REQ-034 req=0001, op_a[0]=0x3F800000, op_b[0]=0x40000000; bench Adder model pulses Ready 3 cycles after En -> done=0001 with result=0x40400000, err=0.
REQ-035 req=0101 held; slice0 = 3.0+4.0, slice2 = 0.5+0.5 -> done[0] first with 0x40E00000, then done[2] with 0x3F800000.
REQ-036 req=1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-037 add_ready tied 0, req=0010 -> done=0010 with err=1 and result=0, exactly TIMEOUT WAIT cycles after ISSUE.
REQ-038 reset driven to 0 during WAIT for requester 3 -> outputs go to reset values immediately and no done pulse. After release with req=1000, service restarts with a fresh add_en.
REQ-039 add_ready held 1 across ISSUE (stale from the previous operation) -> no completion until Ready goes low then high again.

Source files
------------

// File: rtl/fp_arb_pkg.sv
// fp_arb_pkg: shared types and constants for the floating-point adder arbiter
package fp_arb_pkg;
  localparam int FP_W = 32;
  localparam int N_REQ_DEF = 4;
  localparam int TIMEOUT_DEF = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first request at or after ptr
module rr_pick
  import fp_arb_pkg::*;
#(
  parameter int N = N_REQ_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);
  // scan offsets from farthest to nearest so the nearest hit is the last write
  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one external IEEE-754 adder among N_REQ requesters
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [FP_W*N_REQ-1:0] op_a,
  input  logic [FP_W*N_REQ-1:0] op_b,
  output logic [N_REQ-1:0]      done,
  output logic [FP_W-1:0]       result,
  output logic                  err,
  output logic                  busy,
  output logic                  add_en,
  output logic [FP_W-1:0]       add_a,
  output logic [FP_W-1:0]       add_b,
  input  logic [FP_W-1:0]       add_sum,
  input  logic                  add_ready
);
  localparam int IW = idx_w(N_REQ);
  localparam int CW = idx_w(TIMEOUT);
  state_t state;
  logic [IW-1:0] ptr, grant, pick;
  logic pick_ok, rdy_q, rise;
  logic [CW-1:0] cnt;
  logic [FP_W-1:0] sel_a, sel_b;
  logic [N_REQ-1:0] grant_oh;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .idx  (pick),
    .valid(pick_ok)
  );
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    grant_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IW'(i)) begin
        sel_a = op_a[i*FP_W +: FP_W];
        sel_b = op_b[i*FP_W +: FP_W];
      end
      grant_oh[i] = grant == IW'(i);
    end
  end
  // rdy_q tracks add_ready every cycle, so a level already high at ISSUE never counts as completion
  assign rise = add_ready & ~rdy_q;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      grant <= '0;
      cnt <= '0;
      rdy_q <= 1'b0;
      done <= '0;
      result <= '0;
      err <= 1'b0;
      add_en <= 1'b0;
      add_a <= '0;
      add_b <= '0;
    end else begin
      rdy_q <= add_ready;
      case (state)
        IDLE: if (pick_ok) begin
          grant <= pick;
          add_a <= sel_a;
          add_b <= sel_b;
          ptr <= pick == IW'(N_REQ - 1) ? '0 : pick + 1'b1;
          add_en <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          add_en <= 1'b0;
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (rise || cnt == CW'(TIMEOUT - 1)) begin
          done <= grant_oh;
          result <= rise ? add_sum : '0;
          err <= ~rise;
          state <= RESP;
        end else cnt <= cnt + 1'b1;
        RESP: begin
          done <= '0;
          result <= '0;
          err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed checks of arbitration, completion, timeout and reset behaviour
module tb_fp_add_arbiter;
  localparam int N = 4;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [32*N-1:0] op_a = '1, op_b = '1;
  logic [N-1:0] done;
  logic [31:0] result, add_a, add_b, add_sum;
  logic err, busy, add_en, add_ready;
  logic auto_m = 1'b1, rdy_auto = 1'b0, rdy_man = 1'b0;
  logic [31:0] sum_auto = '0, sum_man = '0;
  int dly = 3, cd = 0, cyc, total = 0, bad = 0;
  logic [N-1:0] seen;
  fp_add_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .op_a     (op_a),
    .op_b     (op_b),
    .done     (done),
    .result   (result),
    .err      (err),
    .busy     (busy),
    .add_en   (add_en),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .add_ready(add_ready)
  );
  always #5 clk = ~clk;
  assign add_ready = auto_m ? rdy_auto : rdy_man;
  assign add_sum = auto_m ? sum_auto : sum_man;
  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h40400000, 32'h40800000}: return 32'h40E00000;
      {32'h3F000000, 32'h3F000000}: return 32'h3F800000;
      {32'h40A00000, 32'h40A00000}: return 32'h41200000;
      default: return a ^ b;
    endcase
  endfunction
  // adder model: one-cycle Ready pulse dly cycles after En
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cd <= 0;
      rdy_auto <= 1'b0;
    end else begin
      rdy_auto <= 1'b0;
      if (add_en) begin
        cd <= dly - 1;
        if (dly == 1) begin
          rdy_auto <= 1'b1;
          sum_auto <= fp_model(add_a, add_b);
        end
      end else if (cd > 0) begin
        cd <= cd - 1;
        if (cd == 1) begin
          rdy_auto <= 1'b1;
          sum_auto <= fp_model(add_a, add_b);
        end
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < 200);
    check({tag, "_seen"}, 32'(|done), 32'd1);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    op_a[i*32 +: 32] = a;
    op_b[i*32 +: 32] = b;
  endtask
  initial begin
    req = 4'b1111;
    repeat (2) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_add_en", 32'(add_en), 32'd0);
    check("rst_add_a", add_a, 32'd0);
    check("rst_add_b", add_b, 32'd0);
    // single request, 1.0 + 2.0, Ready 3 cycles after En, req dropped mid-operation
    req = '0;
    dly = 3;
    set_op(0, 32'h3F800000, 32'h40000000);
    reset = 1'b1;
    req = 4'b0001;
    @(negedge clk);
    check("t1_add_en", 32'(add_en), 32'd1);
    check("t1_add_a", add_a, 32'h3F800000);
    check("t1_add_b", add_b, 32'h40000000);
    check("t1_busy", 32'(busy), 32'd1);
    req = '0;
    @(negedge clk);
    check("t1_en_off", 32'(add_en), 32'd0);
    wait_done("t1", cyc);
    check("t1_lat", 32'(cyc), 32'd3);
    check("t1_done", 32'(done), 32'b0001);
    check("t1_result", result, 32'h40400000);
    check("t1_err", 32'(err), 32'd0);
    @(negedge clk);
    check("t1_done_clr", 32'(done), 32'd0);
    check("t1_result_clr", result, 32'd0);
    check("t1_idle", 32'(busy), 32'd0);
    // two held requests served in order 0 then 2
    do_reset();
    dly = 2;
    set_op(0, 32'h40400000, 32'h40800000);
    set_op(2, 32'h3F000000, 32'h3F000000);
    req = 4'b0101;
    wait_done("t2a", cyc);
    check("t2a_done", 32'(done), 32'b0001);
    check("t2a_result", result, 32'h40E00000);
    check("t2a_err", 32'(err), 32'd0);
    wait_done("t2b", cyc);
    check("t2b_done", 32'(done), 32'b0100);
    check("t2b_result", result, 32'h3F800000);
    req = '0;
    // all four held: rotation 0,1,2,3,0,1,2,3 and minimum turnaround
    do_reset();
    dly = 1;
    for (int i = 0; i < N; i++) set_op(i, 32'hA0000000 | i, 32'h00000B00 | (i << 4));
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_done("t3", cyc);
      check($sformatf("t3_lat%0d", k), 32'(cyc), k == 0 ? 32'd3 : 32'd4);
      check($sformatf("t3_done%0d", k), 32'(done), 32'(1 << (k % 4)));
      check($sformatf("t3_result%0d", k), result, 32'hA0000B00 | (k % 4) | ((k % 4) << 4));
    end
    req = '0;
    // Ready tied low: timeout after exactly TO wait cycles
    do_reset();
    auto_m = 1'b0;
    rdy_man = 1'b0;
    sum_man = 32'hFFFFFFFF;
    set_op(1, 32'h7F800000, 32'hFF800000);
    req = 4'b0010;
    wait_done("t4", cyc);
    check("t4_done", 32'(done), 32'b0010);
    check("t4_err", 32'(err), 32'd1);
    check("t4_result", result, 32'd0);
    check("t4_lat", 32'(cyc), 32'(TO + 2));
    req = '0;
    // reset during WAIT aborts, then service restarts
    do_reset();
    auto_m = 1'b1;
    dly = 10;
    set_op(3, 32'h40A00000, 32'h40A00000);
    req = 4'b1000;
    repeat (4) @(negedge clk);
    check("t5_busy_pre", 32'(busy), 32'd1);
    check("t5_add_a_pre", add_a, 32'h40A00000);
    reset = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_add_a", add_a, 32'd0);
    check("t5_add_b", add_b, 32'd0);
    check("t5_add_en", 32'(add_en), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    seen = '0;
    repeat (3) begin
      @(negedge clk);
      seen |= done;
    end
    reset = 1'b1;
    @(negedge clk);
    seen |= done;
    check("t5_no_done", 32'(seen), 32'd0);
    check("t5_reissue", 32'(add_en), 32'd1);
    wait_done("t5", cyc);
    check("t5_done_after", 32'(done), 32'b1000);
    check("t5_result", result, 32'h41200000);
    req = '0;
    // stale Ready high across ISSUE is not a completion
    do_reset();
    auto_m = 1'b0;
    rdy_man = 1'b0;
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    sum_man = 32'h12345678;
    rdy_man = 1'b1;
    req = '0;
    wait_done("t6a", cyc);
    check("t6a_done", 32'(done), 32'b0001);
    check("t6a_result", result, 32'h12345678);
    req = 4'b0010;
    seen = '0;
    repeat (6) begin
      @(negedge clk);
      seen |= done;
    end
    check("t6_stale", 32'(seen), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    sum_man = 32'h0BADF00D;
    rdy_man = 1'b0;
    @(negedge clk);
    rdy_man = 1'b1;
    wait_done("t6b", cyc);
    check("t6b_done", 32'(done), 32'b0010);
    check("t6b_result", result, 32'h0BADF00D);
    check("t6b_err", 32'(err), 32'd0);
    req = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
